// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: frequency-sweep scheduler for a dds core.
// Steps the tuning word from f_start to f_stop in f_step increments.
// Each frequency is held for a programmable dwell of dds_ce cycles.
// The dds is phase-reset once at the start of each sweep.
// Every output is a register loaded from the next-state logic.
module dds_sweep_ctrl #(
    parameter int TW = 10,
    parameter int PW = 15,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic          repeat_en,
    input  logic [TW-1:0] f_start,
    input  logic [TW-1:0] f_stop,
    input  logic [TW-1:0] f_step,
    input  logic [CW-1:0] dwell,
    input  logic [PW-1:0] phase0,
    output logic          dds_rst,
    output logic          dds_ce,
    output logic [TW-1:0] tuning_word,
    output logic [PW-1:0] start_phase,
    output logic          busy,
    output logic          step_strobe,
    output logic          done,
    output logic          cfg_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t        state_reg, state_next;

    logic          dds_rst_reg, dds_rst_next;
    logic          dds_ce_reg, dds_ce_next;
    logic [TW-1:0] tw_reg, tw_next;
    logic [PW-1:0] phase_reg, phase_next;
    logic          busy_reg, busy_next;
    logic          strobe_reg, strobe_next;
    logic          done_reg, done_next;
    logic          err_reg, err_next;
    logic [CW-1:0] cnt_reg, cnt_next;

    // Sweep configuration captured when a start is accepted
    logic [TW-1:0] fstart_reg, fstart_next;
    logic [TW-1:0] fstop_reg, fstop_next;
    logic [TW-1:0] fstep_reg, fstep_next;
    logic [CW-1:0] dwell_last_reg, dwell_last_next;
    logic          repeat_reg, repeat_next;
    logic          up_reg, up_next;

    // Next-frequency arithmetic helpers
    logic [TW:0]   sum_wide;
    logic [TW-1:0] diff_down;
    logic [TW-1:0] tw_up;
    logic [TW-1:0] tw_down;
    logic [TW-1:0] tw_step;
    logic          dwell_expired;
    logic          bad_cfg;

    // Candidate next tuning word; the sum carries one extra bit so an overshoot past the top of the range still clamps
    always_comb begin
        sum_wide  = {1'b0, tw_reg} + {1'b0, fstep_reg};
        diff_down = tw_reg - fstop_reg;
        tw_up     = (sum_wide >= {1'b0, fstop_reg}) ? fstop_reg : sum_wide[TW-1:0];
        tw_down   = (diff_down <= fstep_reg) ? fstop_reg : (tw_reg - fstep_reg);
        tw_step   = up_reg ? tw_up : tw_down;
        dwell_expired = (cnt_reg == dwell_last_reg);
        bad_cfg   = (f_step == '0) && (f_start != f_stop);
    end

    // Next-state and registered-output logic; every output defaults to its idle value
    always_comb begin
        state_next      = state_reg;
        dds_rst_next    = 1'b0;
        dds_ce_next     = 1'b0;
        tw_next         = tw_reg;
        phase_next      = phase_reg;
        busy_next       = 1'b0;
        strobe_next     = 1'b0;
        done_next       = 1'b0;
        err_next        = 1'b0;
        cnt_next        = cnt_reg;
        fstart_next     = fstart_reg;
        fstop_next      = fstop_reg;
        fstep_next      = fstep_reg;
        dwell_last_next = dwell_last_reg;
        repeat_next     = repeat_reg;
        up_next         = up_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if (bad_cfg) begin
                        err_next = 1'b1;
                    end else begin
                        fstart_next     = f_start;
                        fstop_next      = f_stop;
                        fstep_next      = f_step;
                        // A dwell of zero behaves as a dwell of one
                        dwell_last_next = (dwell == '0) ? '0 : (dwell - 1'b1);
                        repeat_next     = repeat_en;
                        up_next         = (f_stop >= f_start);
                        phase_next      = phase0;
                        tw_next         = f_start;
                        dds_rst_next    = 1'b1;
                        busy_next       = 1'b1;
                        state_next      = ST_LOAD;
                    end
                end
            end

            ST_LOAD: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next    = '0;
                    dds_ce_next = 1'b1;
                    busy_next   = 1'b1;
                    state_next  = ST_RUN;
                end
            end

            ST_RUN: begin
                if (abort) begin
                    // Abort wins over a dwell expiry in the same cycle
                    state_next = ST_IDLE;
                end else if (dwell_expired) begin
                    cnt_next = '0;
                    if (tw_reg == fstop_reg) begin
                        if (repeat_reg) begin
                            // Wrap to the start frequency without a phase reset
                            tw_next     = fstart_reg;
                            strobe_next = 1'b1;
                            dds_ce_next = 1'b1;
                            busy_next   = 1'b1;
                        end else begin
                            done_next  = 1'b1;
                            state_next = ST_DONE;
                        end
                    end else begin
                        tw_next     = tw_step;
                        strobe_next = 1'b1;
                        dds_ce_next = 1'b1;
                        busy_next   = 1'b1;
                    end
                end else begin
                    cnt_next    = cnt_reg + 1'b1;
                    dds_ce_next = 1'b1;
                    busy_next   = 1'b1;
                end
            end

            ST_DONE: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, output and configuration registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            dds_rst_reg    <= 1'b1;
            dds_ce_reg     <= 1'b0;
            tw_reg         <= '0;
            phase_reg      <= '0;
            busy_reg       <= 1'b0;
            strobe_reg     <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            cnt_reg        <= '0;
            fstart_reg     <= '0;
            fstop_reg      <= '0;
            fstep_reg      <= '0;
            dwell_last_reg <= '0;
            repeat_reg     <= 1'b0;
            up_reg         <= 1'b1;
        end else begin
            state_reg      <= state_next;
            dds_rst_reg    <= dds_rst_next;
            dds_ce_reg     <= dds_ce_next;
            tw_reg         <= tw_next;
            phase_reg      <= phase_next;
            busy_reg       <= busy_next;
            strobe_reg     <= strobe_next;
            done_reg       <= done_next;
            err_reg        <= err_next;
            cnt_reg        <= cnt_next;
            fstart_reg     <= fstart_next;
            fstop_reg      <= fstop_next;
            fstep_reg      <= fstep_next;
            dwell_last_reg <= dwell_last_next;
            repeat_reg     <= repeat_next;
            up_reg         <= up_next;
        end
    end

    assign dds_rst     = dds_rst_reg;
    assign dds_ce      = dds_ce_reg;
    assign tuning_word = tw_reg;
    assign start_phase = phase_reg;
    assign busy        = busy_reg;
    assign step_strobe = strobe_reg;
    assign done        = done_reg;
    assign cfg_err     = err_reg;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb_dds_sweep_ctrl: table-driven sweeps plus hand-written corner sequences.
module tb_dds_sweep_ctrl;

    localparam int TW = 10;
    localparam int PW = 15;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          repeat_en;
    logic [TW-1:0] f_start;
    logic [TW-1:0] f_stop;
    logic [TW-1:0] f_step;
    logic [CW-1:0] dwell;
    logic [PW-1:0] phase0;
    logic          dds_rst;
    logic          dds_ce;
    logic [TW-1:0] tuning_word;
    logic [PW-1:0] start_phase;
    logic          busy;
    logic          step_strobe;
    logic          done;
    logic          cfg_err;

    int vectors = 0;
    int miscompares = 0;

    dds_sweep_ctrl #(.TW(TW), .PW(PW), .CW(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .repeat_en   (repeat_en),
        .f_start     (f_start),
        .f_stop      (f_stop),
        .f_step      (f_step),
        .dwell       (dwell),
        .phase0      (phase0),
        .dds_rst     (dds_rst),
        .dds_ce      (dds_ce),
        .tuning_word (tuning_word),
        .start_phase (start_phase),
        .busy        (busy),
        .step_strobe (step_strobe),
        .done        (done),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    // One single-shot sweep: configuration plus the hand-computed frequency list
    typedef struct {
        logic [TW-1:0] fs;
        logic [TW-1:0] fe;
        logic [TW-1:0] st;
        logic [CW-1:0] dw;
        logic [PW-1:0] ph;
        int            de;   // effective dwell
        int            n;    // number of frequencies
        logic [TW-1:0] t0, t1, t2, t3;
    } sweep_t;

    sweep_t tbl [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [TW-1:0] tw_at(input sweep_t s, input int i);
        case (i)
            0:       return s.t0;
            1:       return s.t1;
            2:       return s.t2;
            default: return s.t3;
        endcase
    endfunction

    task automatic run_sweep(input int k);
        sweep_t s;
        s = tbl[k];
        f_start = s.fs; f_stop = s.fe; f_step = s.st; dwell = s.dw;
        phase0 = s.ph; repeat_en = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("load_rst", 32'(dds_rst), 32'd1);
        chk("load_busy", 32'(busy), 32'd1);
        chk("load_ce", 32'(dds_ce), 32'd0);
        chk("load_tw", 32'(tuning_word), 32'(s.t0));
        chk("load_phase", 32'(start_phase), 32'(s.ph));
        for (int i = 0; i < s.n; i++) begin
            for (int c = 0; c < s.de; c++) begin
                tick();
                chk("run_ce", 32'(dds_ce), 32'd1);
                chk("run_tw", 32'(tuning_word), 32'(tw_at(s, i)));
                chk("run_strobe", 32'(step_strobe), (i > 0 && c == 0) ? 32'd1 : 32'd0);
                chk("run_rst", 32'(dds_rst), 32'd0);
                chk("run_done", 32'(done), 32'd0);
            end
        end
        tick();
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_ce", 32'(dds_ce), 32'd0);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_tw", 32'(tuning_word), 32'(tw_at(s, s.n - 1)));
        tick();
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_tw", 32'(tuning_word), 32'(tw_at(s, s.n - 1)));
        $display("sweep %0d: %0d -> %0d step %0d dwell %0d checked", k, s.fs, s.fe, s.st, s.dw);
    endtask

    initial begin
        //          fs    fe    st   dw  ph      de n  t0   t1   t2   t3
        tbl[0] = '{10'd100, 10'd130, 10'd10, 16'd4, 15'h0011, 4, 4, 10'd100, 10'd110, 10'd120, 10'd130};
        tbl[1] = '{10'd100, 10'd125, 10'd10, 16'd1, 15'h0022, 1, 4, 10'd100, 10'd110, 10'd120, 10'd125};
        tbl[2] = '{10'd200, 10'd170, 10'd15, 16'd2, 15'h7fff, 2, 3, 10'd200, 10'd185, 10'd170, 10'd0};
        tbl[3] = '{10'd200, 10'd170, 10'd15, 16'd0, 15'h0100, 1, 3, 10'd200, 10'd185, 10'd170, 10'd0};
        tbl[4] = '{10'd7,   10'd7,   10'd0,  16'd2, 15'h0003, 2, 1, 10'd7,   10'd0,   10'd0,   10'd0};
        tbl[5] = '{10'd5,   10'd0,   10'd3,  16'd1, 15'h0004, 1, 3, 10'd5,   10'd2,   10'd0,   10'd0};
        tbl[6] = '{10'd0,   10'd1023, 10'd600, 16'd1, 15'h1555, 1, 3, 10'd0, 10'd600, 10'd1023, 10'd0};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; repeat_en = 1'b0;
        f_start = '0; f_stop = '0; f_step = '0; dwell = '0; phase0 = '0;
        tick();
        tick();
        chk("rst_dds_rst", 32'(dds_rst), 32'd1);
        chk("rst_ce", 32'(dds_ce), 32'd0);
        chk("rst_tw", 32'(tuning_word), 32'd0);
        chk("rst_phase", 32'(start_phase), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_flags", {29'd0, step_strobe, done, cfg_err}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_dds_rst", 32'(dds_rst), 32'd0);
        $display("reset: checked");

        for (int k = 0; k < 7; k++) run_sweep(k);

        // Rejected configuration: step 0 with distinct endpoints
        f_start = 10'd5; f_stop = 10'd9; f_step = 10'd0; dwell = 16'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("err_pulse", 32'(cfg_err), 32'd1);
        chk("err_busy", 32'(busy), 32'd0);
        chk("err_rst", 32'(dds_rst), 32'd0);
        chk("err_tw", 32'(tuning_word), 32'd1023);
        tick();
        chk("err_clear", 32'(cfg_err), 32'd0);
        chk("err_idle", 32'(busy), 32'd0);
        $display("cfg_err: checked");

        // Repeat mode with an ignored start during RUN, then abort on a dwell-expiry cycle
        f_start = 10'd10; f_stop = 10'd30; f_step = 10'd10; dwell = 16'd3;
        repeat_en = 1'b1; phase0 = 15'h1234;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rep_load_rst", 32'(dds_rst), 32'd1);
        chk("rep_load_tw", 32'(tuning_word), 32'd10);
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 3; i++) begin
                for (int c = 0; c < 3; c++) begin
                    tick();
                    start = 1'b0;
                    f_start = 10'd10;
                    chk("rep_ce", 32'(dds_ce), 32'd1);
                    chk("rep_tw", 32'(tuning_word), 32'(10 + 10 * i));
                    chk("rep_strobe", 32'(step_strobe), (c == 0 && !(p == 0 && i == 0)) ? 32'd1 : 32'd0);
                    chk("rep_rst", 32'(dds_rst), 32'd0);
                    chk("rep_busy", 32'(busy), 32'd1);
                    if (p == 0 && i == 1 && c == 0) begin
                        start = 1'b1;
                        f_start = 10'd500;
                    end
                end
            end
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("wrap_tw", 32'(tuning_word), 32'd10);
            chk("wrap_strobe", 32'(step_strobe), (c == 0) ? 32'd1 : 32'd0);
            chk("wrap_rst", 32'(dds_rst), 32'd0);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_ce", 32'(dds_ce), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_tw", 32'(tuning_word), 32'd10);
        chk("abort_strobe", 32'(step_strobe), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("post_abort_done", 32'(done), 32'd0);
            chk("post_abort_ce", 32'(dds_ce), 32'd0);
        end
        $display("repeat/abort: checked");

        // Reset in the middle of a sweep
        f_start = 10'd100; f_stop = 10'd130; f_step = 10'd10; dwell = 16'd4;
        repeat_en = 1'b0; phase0 = 15'h0042;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("pre_rst_ce", 32'(dds_ce), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_dds_rst", 32'(dds_rst), 32'd1);
        chk("midrst_ce", 32'(dds_ce), 32'd0);
        chk("midrst_tw", 32'(tuning_word), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_phase", 32'(start_phase), 32'd0);
        tick();
        chk("after_rst_dds_rst", 32'(dds_rst), 32'd0);
        chk("after_rst_busy", 32'(busy), 32'd0);
        $display("mid-sweep reset: checked");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
